// File: rtl/pc_stack_unit_if.sv
// Purpose : controller <-> program-counter unit bundle (command side plus PC/stack status side).
// Latency : pure wiring; no storage of its own.
// Backpressure: none here; stall travels with the command signals and freezes the unit.
//
// Signals:
//   stall, cmd, target, offset, err_clr         controller -> unit
//   pc_out, stack_count, stack_full, stack_empty,
//   ovf_err, unf_err                            unit -> controller / fetch bus
//   last_pc, flow_chg                           unit -> observer, only with PC_TRACE_EN
//
// ADDR_WIDTH and STACK_DEPTH must match the values given to pc_stack_unit.
interface pc_stack_unit_if #(
    parameter int ADDR_WIDTH  = 24,
    parameter int STACK_DEPTH = 8
);
    localparam int CW = $clog2(STACK_DEPTH) + 1;

    logic                  stall;
    logic [2:0]            cmd;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  err_clr;

    logic [ADDR_WIDTH-1:0] pc_out;
    logic [CW-1:0]         stack_count;
    logic                  stack_full;
    logic                  stack_empty;
    logic                  ovf_err;
    logic                  unf_err;

`ifdef PC_TRACE_EN
    logic [ADDR_WIDTH-1:0] last_pc;
    logic                  flow_chg;

    modport master (
        output stall, cmd, target, offset, err_clr,
        input  pc_out, stack_count, stack_full, stack_empty, ovf_err, unf_err,
        input  last_pc, flow_chg
    );

    modport slave (
        input  stall, cmd, target, offset, err_clr,
        output pc_out, stack_count, stack_full, stack_empty, ovf_err, unf_err,
        output last_pc, flow_chg
    );
`else
    modport master (
        output stall, cmd, target, offset, err_clr,
        input  pc_out, stack_count, stack_full, stack_empty, ovf_err, unf_err
    );

    modport slave (
        input  stall, cmd, target, offset, err_clr,
        output pc_out, stack_count, stack_full, stack_empty, ovf_err, unf_err
    );
`endif

endinterface

// File: rtl/pc_stack_unit.sv
// Purpose : program counter with increment, jump, relative branch and call/return via a LIFO stack.
// Latency : every command takes effect on the falling clock edge it is sampled on; outputs are registered.
// Backpressure: stall=1 freezes pc, stack and trace state; only err_clr still acts.
//
// Ports:
//   clock  - all state changes on its falling edge
//   reset  - asynchronous, active-high; pc -> RESET_VECTOR, stack emptied, error flags cleared
//   bus    - pc_stack_unit_if.slave: stall/cmd/target/offset/err_clr in,
//            pc_out/stack_count/stack_full/stack_empty/ovf_err/unf_err out
//
// Optional build macro PC_TRACE_EN adds last_pc and flow_chg on the interface.
//
// cmd encoding: 0 NOP/INC, 1 JUMP, 2 BRANCH_REL, 3 CALL, 4 RET, 5..7 HOLD.
// STACK_DEPTH must be a power of two in 2..64.
module pc_stack_unit #(
    parameter int                    ADDR_WIDTH   = 24,
    parameter int                    STEP         = 1,
    parameter int                    STACK_DEPTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic           clock,
    input  logic           reset,
    pc_stack_unit_if.slave bus
);

    localparam int PW = $clog2(STACK_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_JUMP = 3'd1;
    localparam logic [2:0] CMD_BREL = 3'd2;
    localparam logic [2:0] CMD_CALL = 3'd3;
    localparam logic [2:0] CMD_RET  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] STEP_W  = ADDR_WIDTH'(STEP);
    localparam logic [CW-1:0]         DEPTH_W = CW'(STACK_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [CW-1:0]         cnt_q;
    logic                  ovf_q;
    logic                  unf_q;

    // Return-address storage. Contents are never reset: an entry is only
    // read after it has been written by a push.
    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

    // ------------------------------------------------------------------
    // Derived values
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] seq_pc;
    logic [ADDR_WIDTH-1:0] rel_pc;
    logic [PW-1:0]         push_idx;
    logic [PW-1:0]         top_idx;
    logic [ADDR_WIDTH-1:0] top_entry;
    logic                  is_full;
    logic                  is_empty;

    // Additions wrap modulo 2^ADDR_WIDTH by width truncation; offset is
    // two's complement so the same adder covers backward branches.
    assign seq_pc    = pc_q + STEP_W;
    assign rel_pc    = pc_q + bus.offset;

    // The count doubles as the stack pointer: the next free slot is at
    // cnt_q, the top of stack at cnt_q-1. When full, the low bits wrap to
    // zero, but no push happens in that state.
    assign push_idx  = cnt_q[PW-1:0];
    assign top_idx   = cnt_q[PW-1:0] - PW'(1);
    assign top_entry = stack_mem[top_idx];

    assign is_full   = (cnt_q == DEPTH_W);
    assign is_empty  = (cnt_q == '0);

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [CW-1:0]         cnt_d;
    logic                  push_en;
    logic                  ovf_set;
    logic                  unf_set;
    logic                  redirect;   // pc moved by something other than +STEP
    logic                  pc_wr;      // command writes pc (everything but HOLD)

    always_comb begin
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        push_en  = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        redirect = 1'b0;
        pc_wr    = 1'b0;

        if (!bus.stall) begin
            case (bus.cmd)
                CMD_NOP: begin
                    pc_d  = seq_pc;
                    pc_wr = 1'b1;
                end
                CMD_JUMP: begin
                    pc_d     = bus.target;
                    pc_wr    = 1'b1;
                    redirect = 1'b1;
                end
                CMD_BREL: begin
                    pc_d     = rel_pc;
                    pc_wr    = 1'b1;
                    redirect = 1'b1;
                end
                CMD_CALL: begin
                    pc_wr = 1'b1;
                    if (is_full) begin
                        // Rejected call falls through to the next instruction.
                        pc_d    = seq_pc;
                        ovf_set = 1'b1;
                    end else begin
                        pc_d     = bus.target;
                        cnt_d    = cnt_q + CW'(1);
                        push_en  = 1'b1;
                        redirect = 1'b1;
                    end
                end
                CMD_RET: begin
                    pc_wr = 1'b1;
                    if (is_empty) begin
                        pc_d    = seq_pc;
                        unf_set = 1'b1;
                    end else begin
                        pc_d     = top_entry;
                        cnt_d    = cnt_q - CW'(1);
                        redirect = 1'b1;
                    end
                end
                default: begin
                    // HOLD and unused encodings leave everything untouched.
                end
            endcase
        end
    end

    // A new error in the same edge as err_clr wins, so set beats clear.
    logic ovf_d;
    logic unf_d;
    assign ovf_d = ovf_set | (ovf_q & ~bus.err_clr);
    assign unf_d = unf_set | (unf_q & ~bus.err_clr);

    // ------------------------------------------------------------------
    // Registers (falling edge, async active-high reset)
    // ------------------------------------------------------------------
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Write port has no reset; gating with reset keeps a command that is
    // pending while reset is held from leaving a stray entry behind.
    always_ff @(negedge clock) begin
        if (push_en && !reset) begin
            stack_mem[push_idx] <= seq_pc;
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.stack_count = cnt_q;
    assign bus.stack_full  = is_full;
    assign bus.stack_empty = is_empty;
    assign bus.ovf_err     = ovf_q;
    assign bus.unf_err     = unf_q;

`ifdef PC_TRACE_EN
    // ------------------------------------------------------------------
    // Trace: previous pc and a one-edge flow-change pulse
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] last_pc_q;
    logic                  flow_chg_q;

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            last_pc_q  <= RESET_VECTOR;
            flow_chg_q <= 1'b0;
        end else if (bus.stall) begin
            // last_pc holds, the pulse is dropped.
            flow_chg_q <= 1'b0;
        end else begin
            // HOLD does not update pc, so it does not shift last_pc either.
            if (pc_wr) begin
                last_pc_q <= pc_q;
            end
            flow_chg_q <= redirect;
        end
    end

    assign bus.last_pc  = last_pc_q;
    assign bus.flow_chg = flow_chg_q;
`endif

endmodule

// File: tb/tb_pc_stack_unit.sv
// Purpose : directed self-checking bench for pc_stack_unit (24-bit, STEP=1, depth 8, reset vector 0).
// Latency : inputs are driven between edges; outputs are sampled 1 time unit after each falling edge.
// Backpressure: stall is exercised together with err_clr and a pending JUMP.
module tb_pc_stack_unit;

    localparam int AW = 24;
    localparam int SD = 8;

    localparam logic [2:0] NOP  = 3'd0;
    localparam logic [2:0] JUMP = 3'd1;
    localparam logic [2:0] BREL = 3'd2;
    localparam logic [2:0] CALL = 3'd3;
    localparam logic [2:0] RET  = 3'd4;
    localparam logic [2:0] HOLD = 3'd5;

    logic clock;
    logic reset;

    int n_cmp;
    int n_err;

    pc_stack_unit_if #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) bus ();

    pc_stack_unit #(
        .ADDR_WIDTH  (AW),
        .STEP        (1),
        .STACK_DEPTH (SD),
        .RESET_VECTOR(24'h000000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one command, let one falling edge consume it, then settle.
    task automatic step(input logic [2:0] c, input logic [AW-1:0] t, input logic [AW-1:0] o,
                        input logic s, input logic ec);
        bus.cmd     = c;
        bus.target  = t;
        bus.offset  = o;
        bus.stall   = s;
        bus.err_clr = ec;
        @(negedge clock);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;

        reset       = 1'b1;
        bus.cmd     = HOLD;
        bus.target  = '0;
        bus.offset  = '0;
        bus.stall   = 1'b0;
        bus.err_clr = 1'b0;
        #1;

        // Reset state, before any clock edge.
        check("rst_pc",    bus.pc_out,      32'h0);
        check("rst_count", bus.stack_count, 32'd0);
        check("rst_empty", bus.stack_empty, 32'd1);
        check("rst_full",  bus.stack_full,  32'd0);
        check("rst_ovf",   bus.ovf_err,     32'd0);
        check("rst_unf",   bus.unf_err,     32'd0);

        // A command presented while reset is held is ignored.
        step(JUMP, 24'h000555, 24'h0, 1'b0, 1'b0);
        check("rst_hold_pc", bus.pc_out, 32'h0);
        #2 reset = 1'b0;

        // Sequential increment.
        step(NOP, 24'h0, 24'h0, 1'b0, 1'b0);
        check("nop1", bus.pc_out, 32'h000001);
        step(NOP, 24'h0, 24'h0, 1'b0, 1'b0);
        check("nop2", bus.pc_out, 32'h000002);
        step(NOP, 24'h0, 24'h0, 1'b0, 1'b0);
        check("nop3", bus.pc_out, 32'h000003);
        check("nop_empty", bus.stack_empty, 32'd1);

        // Backward relative branch and wrap-around.
        step(JUMP, 24'h000010, 24'h0, 1'b0, 1'b0);
        check("jump10", bus.pc_out, 32'h000010);
        step(BREL, 24'h0, 24'hFFFFFC, 1'b0, 1'b0);
        check("brel_m4", bus.pc_out, 32'h00000C);
        step(BREL, 24'h0, 24'h000100, 1'b0, 1'b0);
        check("brel_p100", bus.pc_out, 32'h00010C);
        step(JUMP, 24'hFFFFFF, 24'h0, 1'b0, 1'b0);
        step(NOP, 24'h0, 24'h0, 1'b0, 1'b0);
        check("wrap", bus.pc_out, 32'h000000);

        // Nested call / return.
        step(JUMP, 24'h000100, 24'h0, 1'b0, 1'b0);
        step(CALL, 24'h000200, 24'h0, 1'b0, 1'b0);
        check("call1_pc",  bus.pc_out,      32'h000200);
        check("call1_cnt", bus.stack_count, 32'd1);
        step(CALL, 24'h000300, 24'h0, 1'b0, 1'b0);
        check("call2_pc",  bus.pc_out,      32'h000300);
        check("call2_cnt", bus.stack_count, 32'd2);
        step(RET, 24'h0, 24'h0, 1'b0, 1'b0);
        check("ret1_pc",  bus.pc_out,      32'h000201);
        check("ret1_cnt", bus.stack_count, 32'd1);
        step(RET, 24'h0, 24'h0, 1'b0, 1'b0);
        check("ret2_pc",    bus.pc_out,      32'h000101);
        check("ret2_empty", bus.stack_empty, 32'd1);

        // Fill the stack: pushes 0x1001, 0x2001, 0x2011, ... 0x2061.
        step(JUMP, 24'h001000, 24'h0, 1'b0, 1'b0);
        for (int i = 0; i < SD; i++) begin
            step(CALL, 24'h002000 + AW'(i * 16), 24'h0, 1'b0, 1'b0);
        end
        check("fill_pc",   bus.pc_out,      32'h002070);
        check("fill_cnt",  bus.stack_count, 32'd8);
        check("fill_full", bus.stack_full,  32'd1);
        check("fill_ovf0", bus.ovf_err,     32'd0);
        step(CALL, 24'h003000, 24'h0, 1'b0, 1'b0);
        check("ovf_pc",  bus.pc_out,      32'h002071);
        check("ovf_err", bus.ovf_err,     32'd1);
        check("ovf_cnt", bus.stack_count, 32'd8);

        // Drain: first pop is the newest entry, last pop the oldest.
        step(RET, 24'h0, 24'h0, 1'b0, 1'b0);
        check("drain1_pc",  bus.pc_out,      32'h002061);
        check("drain1_cnt", bus.stack_count, 32'd7);
        for (int i = 1; i < SD; i++) begin
            step(RET, 24'h0, 24'h0, 1'b0, 1'b0);
        end
        check("drain8_pc",    bus.pc_out,      32'h001001);
        check("drain8_empty", bus.stack_empty, 32'd1);
        check("drain8_unf0",  bus.unf_err,     32'd0);
        step(RET, 24'h0, 24'h0, 1'b0, 1'b0);
        check("unf_pc",     bus.pc_out,  32'h001002);
        check("unf_err",    bus.unf_err, 32'd1);
        check("unf_ovf_st", bus.ovf_err, 32'd1);

        // Stall blocks the jump but err_clr still clears both flags.
        step(JUMP, 24'h000555, 24'h0, 1'b1, 1'b1);
        check("stall_pc",  bus.pc_out,  32'h001002);
        check("stall_ovf", bus.ovf_err, 32'd0);
        check("stall_unf", bus.unf_err, 32'd0);

        // New error and err_clr on the same edge: error wins.
        step(RET, 24'h0, 24'h0, 1'b0, 1'b1);
        check("errwin_pc",  bus.pc_out,  32'h001003);
        check("errwin_unf", bus.unf_err, 32'd1);
        step(HOLD, 24'h0, 24'h0, 1'b0, 1'b1);
        check("clr_unf", bus.unf_err, 32'd0);
        check("hold_pc", bus.pc_out,  32'h001003);
        step(3'd7, 24'h000777, 24'h0, 1'b0, 1'b0);
        check("cmd7_pc", bus.pc_out, 32'h001003);

        // CALL immediately followed by RET returns the just-pushed address.
        step(CALL, 24'h000700, 24'h0, 1'b0, 1'b0);
        step(RET, 24'h0, 24'h0, 1'b0, 1'b0);
        check("callret_pc", bus.pc_out, 32'h001004);

        // Reset pulsed between edges acts without a clock edge.
        step(CALL, 24'h000700, 24'h0, 1'b0, 1'b0);
        check("pre_rst_cnt", bus.stack_count, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_pc",  bus.pc_out,      32'h0);
        check("async_rst_cnt", bus.stack_count, 32'd0);
        reset = 1'b0;

`ifdef PC_TRACE_EN
        check("tr_rst_last", bus.last_pc,  32'h0);
        check("tr_rst_flow", bus.flow_chg, 32'd0);
        step(JUMP, 24'h000010, 24'h0, 1'b0, 1'b0);
        step(JUMP, 24'h000040, 24'h0, 1'b0, 1'b0);
        check("tr_jump_last", bus.last_pc,  32'h000010);
        check("tr_jump_flow", bus.flow_chg, 32'd1);
        step(NOP, 24'h0, 24'h0, 1'b0, 1'b0);
        check("tr_nop_flow", bus.flow_chg, 32'd0);
        check("tr_nop_last", bus.last_pc,  32'h000040);
        step(JUMP, 24'h000080, 24'h0, 1'b0, 1'b0);
        step(JUMP, 24'h000999, 24'h0, 1'b1, 1'b0);
        check("tr_stall_flow", bus.flow_chg, 32'd0);
        check("tr_stall_last", bus.last_pc,  32'h000041);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
